// File: rtl/codec_i2s_intf.sv
// codec_i2s_intf
//   I2S codec interface and the single source of the sample strobe for the
//   effect cores. Generates MCLK/SCLK/LRCLK and the codec reset, deserializes
//   the ADC stream into lft_in/rht_in with VALID, and serializes the core's
//   lft_out/rht_out back to the DAC one frame later.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   MCLK, SCLK, LRCLK   codec master clock, bit clock, word select (0 = left)
//   codec_rst_n         codec reset, held low RST_CYC clocks after rst_n release
//   adc_dat / dac_dat   serial data from / to the codec
//   lft_in, rht_in      captured signed stereo pair, stable between captures
//   VALID               high from capture to the end of the frame
//   lft_out, rht_out    processed pair, read only in the frame-wrap cycle
module codec_i2s_intf #(
  parameter int MCLK_HALF = 2,
  parameter int SCLK_HALF = 8,
  parameter int SLOT_BITS = 32,
  parameter int RST_CYC   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               MCLK,
  output logic               SCLK,
  output logic               LRCLK,
  output logic               codec_rst_n,
  input  logic               adc_dat,
  output logic               dac_dat,
  output logic signed [15:0] lft_in,
  output logic signed [15:0] rht_in,
  output logic               VALID,
  input  logic signed [15:0] lft_out,
  input  logic signed [15:0] rht_out
);

  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SW = $clog2(2 * SCLK_HALF);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int RW = $clog2(RST_CYC + 1);

  localparam logic [MW-1:0] MC_LAST = MW'(MCLK_HALF - 1);
  localparam logic [SW-1:0] SC_RISE = SW'(SCLK_HALF - 1);
  localparam logic [SW-1:0] SC_FALL = SW'(2 * SCLK_HALF - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] BC_SLOT = BW'(SLOT_BITS);
  localparam logic [BW-1:0] BC_CAP  = BW'(SLOT_BITS + 16);
  localparam logic [BW-1:0] P_LSB   = BW'(16);
  localparam logic [RW-1:0] RC_LAST = RW'(RST_CYC - 1);

  logic [MW-1:0] mc;
  logic [SW-1:0] sc;
  logic [BW-1:0] bc;
  logic [BW-1:0] bc_nxt;
  logic [RW-1:0] rc;
  logic          armed;     // a full frame has completed with the codec out of reset
  logic          tx_en;     // previous frame had a VALID window, so TX data is meaningful
  logic          sc_rise;
  logic          sc_fall;
  logic          bc_wrap;
  logic          rx_shift;
  logic          cap_hit;

  logic signed [15:0] lft_sr_p0;
  logic signed [15:0] rht_sr_p0;
  logic signed [15:0] tx_lft_p0;
  logic signed [15:0] tx_rht_p0;

  // Position inside the current channel slot; 0 is the I2S delay bit.
  function automatic logic [BW-1:0] slot_pos(input logic [BW-1:0] b);
    return (b >= BC_SLOT) ? (b - BC_SLOT) : b;
  endfunction

  function automatic logic is_data_pos(input logic [BW-1:0] p);
    return (p != '0) && (p <= P_LSB);
  endfunction

  // Serial bit for bit position b: MSB at slot position 1, zero elsewhere.
  function automatic logic tx_bit(input logic [BW-1:0] b,
                                  input logic [15:0]   l,
                                  input logic [15:0]   r);
    logic [BW-1:0] p;
    logic [BW-1:0] idx;
    p   = slot_pos(b);
    idx = P_LSB - p;
    if (!is_data_pos(p)) return 1'b0;
    return (b < BC_SLOT) ? l[idx[3:0]] : r[idx[3:0]];
  endfunction

  always_comb begin
    sc_rise  = (sc == SC_RISE);
    sc_fall  = (sc == SC_FALL);
    bc_wrap  = sc_fall && (bc == BC_LAST);
    bc_nxt   = bc_wrap ? '0 : bc + 1'b1;
    rx_shift = sc_rise && is_data_pos(slot_pos(bc));
    cap_hit  = sc_rise && (bc == BC_CAP) && armed;
  end

  // ---- Stage: clock generation (MCLK, SCLK, bit counter, LRCLK) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc    <= '0;
      MCLK  <= 1'b0;
      sc    <= '0;
      SCLK  <= 1'b0;
      bc    <= '0;
      LRCLK <= 1'b0;
    end else begin
      if (mc == MC_LAST) begin
        mc   <= '0;
        MCLK <= ~MCLK;
      end else begin
        mc <= mc + 1'b1;
      end
      sc <= sc_fall ? '0 : sc + 1'b1;
      if (sc_rise) SCLK <= 1'b1;
      if (sc_fall) begin
        SCLK  <= 1'b0;
        bc    <= bc_nxt;
        LRCLK <= (bc_nxt >= BC_SLOT);
      end
    end
  end

  // ---- Stage: codec reset, frame gating, capture and DAC bit ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc          <= '0;
      codec_rst_n <= 1'b0;
      armed       <= 1'b0;
      tx_en       <= 1'b0;
      VALID       <= 1'b0;
      lft_in      <= '0;
      rht_in      <= '0;
      dac_dat     <= 1'b0;
    end else begin
      if (!codec_rst_n) begin
        if (rc == RC_LAST) codec_rst_n <= 1'b1;
        else               rc          <= rc + 1'b1;
      end
      if (bc_wrap) begin
        armed <= armed | codec_rst_n;
        tx_en <= armed;
        VALID <= 1'b0;
      end
      // The right LSB is on adc_dat in this very cycle, so fold it in directly.
      if (cap_hit) begin
        VALID  <= 1'b1;
        lft_in <= lft_sr_p0;
        rht_in <= {rht_sr_p0[14:0], adc_dat};
      end
      if (sc_fall) dac_dat <= tx_en && tx_bit(bc_nxt, tx_lft_p0, tx_rht_p0);
    end
  end

  // ---- Stage: RX shift registers and TX holding registers ----
  // Shift registers always receive 16 fresh bits before any capture, and the
  // holding registers are rewritten every frame, so neither needs a reset.
  always_ff @(posedge clk) begin
    if (rx_shift) begin
      if (bc < BC_SLOT) lft_sr_p0 <= {lft_sr_p0[14:0], adc_dat};
      else              rht_sr_p0 <= {rht_sr_p0[14:0], adc_dat};
    end
    if (bc_wrap) begin
      tx_lft_p0 <= lft_out;
      tx_rht_p0 <= rht_out;
    end
  end

endmodule

// File: tb/tb_codec_i2s_intf.sv
module tb_codec_i2s_intf;

  localparam int MH = 2;
  localparam int SH = 8;
  localparam int SA = 32;
  localparam int SB = 17;
  localparam int RC = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mclk_a, sclk_a, lrclk_a, crst_a, adc_a, dac_a, valid_a;
  logic [15:0] lin_a, rin_a, lo_a, ro_a;
  logic        mclk_b, sclk_b, lrclk_b, crst_b, adc_b, dac_b, valid_b;
  logic [15:0] lin_b, rin_b, lo_b, ro_b;

  codec_i2s_intf #(.MCLK_HALF(MH), .SCLK_HALF(SH), .SLOT_BITS(SA), .RST_CYC(RC)) dut_a (
    .clk(clk), .rst_n(rst_n), .MCLK(mclk_a), .SCLK(sclk_a), .LRCLK(lrclk_a),
    .codec_rst_n(crst_a), .adc_dat(adc_a), .dac_dat(dac_a), .lft_in(lin_a),
    .rht_in(rin_a), .VALID(valid_a), .lft_out(lo_a), .rht_out(ro_a));

  codec_i2s_intf #(.MCLK_HALF(MH), .SCLK_HALF(SH), .SLOT_BITS(SB), .RST_CYC(RC)) dut_b (
    .clk(clk), .rst_n(rst_n), .MCLK(mclk_b), .SCLK(sclk_b), .LRCLK(lrclk_b),
    .codec_rst_n(crst_b), .adc_dat(adc_b), .dac_dat(dac_b), .lft_in(lin_b),
    .rht_in(rin_b), .VALID(valid_b), .lft_out(lo_b), .rht_out(ro_b));

  // Per-frame sample tables (indexed by frame number mod 8, frame 0 starts at release).
  logic [15:0] rx_l_tab [8] = '{16'h1111, 16'h2222, 16'h8001, 16'hA5C3, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] rx_r_tab [8] = '{16'h3333, 16'h4444, 16'h7FFE, 16'h5A3C, 16'hFFFF, 16'h0000, 16'h8000, 16'h0001};
  logic [15:0] tx_l_tab [8] = '{16'hDEAD, 16'hBEEF, 16'hC0DE, 16'h1234, 16'h8000, 16'h7FFF, 16'h0F0F, 16'hAAAA};
  logic [15:0] tx_r_tab [8] = '{16'h0BAD, 16'hF00D, 16'h5555, 16'hFEDC, 16'h0001, 16'hFFFE, 16'hF0F0, 16'h3C3C};

  int cyc = 0;
  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  // Expected outputs at cycle c after release for a build with slot size s:
  // {MCLK, SCLK, LRCLK, codec_rst_n, dac_dat, VALID, lft_in, rht_in}
  function automatic logic [37:0] model(input int c, input int s);
    int fl, f, q, b, p, fa, vs;
    logic [15:0] l, r, tv;
    logic m, sk, lr, cr, d, v;
    fl = 4 * SH * s;
    f  = c / fl;
    q  = c % fl;
    b  = (c / (2 * SH)) % (2 * s);
    p  = b % s;
    fa = RC / fl + 1;                      // first frame allowed to capture
    vs = (s + 16) * 2 * SH + SH;           // frame offset where VALID appears
    m  = ((c / MH) % 2) == 1;
    sk = (c % (2 * SH)) >= SH;
    lr = b >= s;
    cr = c >= RC;
    v  = (f >= fa) && (q >= vs);
    if (v) begin
      l = rx_l_tab[f % 8]; r = rx_r_tab[f % 8];
    end else if (f - 1 >= fa) begin
      l = rx_l_tab[(f - 1) % 8]; r = rx_r_tab[(f - 1) % 8];
    end else begin
      l = 16'h0; r = 16'h0;
    end
    tv = lr ? tx_r_tab[f % 8] : tx_l_tab[f % 8];
    d  = (f >= fa + 1) && (p >= 1) && (p <= 16) && tv[16 - p];
    return {m, sk, lr, cr, d, v, l, r};
  endfunction

  function automatic logic adc_bit(input int c, input int s, input logic pad);
    int f, b, p;
    logic [15:0] v;
    f = c / (4 * SH * s);
    b = (c / (2 * SH)) % (2 * s);
    p = b % s;
    v = (b >= s) ? rx_r_tab[f % 8] : rx_l_tab[f % 8];
    if (p >= 1 && p <= 16) return v[16 - p];
    return pad;
  endfunction

  // Real next-frame sample only inside the VALID window, junk everywhere else.
  function automatic logic [15:0] tx_drive(input int c, input int s, input logic rch, input logic [15:0] junk);
    int fl, f, q;
    fl = 4 * SH * s;
    f  = c / fl;
    q  = c % fl;
    if (q >= (s + 16) * 2 * SH + SH) return rch ? tx_r_tab[(f + 1) % 8] : tx_l_tab[(f + 1) % 8];
    return junk;
  endfunction

  function automatic logic [37:0] pack_a();
    return {mclk_a, sclk_a, lrclk_a, crst_a, dac_a, valid_a, lin_a, rin_a};
  endfunction

  function automatic logic [37:0] pack_b();
    return {mclk_b, sclk_b, lrclk_b, crst_b, dac_b, valid_b, lin_b, rin_b};
  endfunction

  task automatic check(input string nm, input logic [37:0] act, input logic [37:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic drive();
    adc_a = adc_bit(cyc, SA, 1'($urandom));
    adc_b = adc_bit(cyc, SB, 1'($urandom));
    lo_a  = tx_drive(cyc, SA, 1'b0, 16'($urandom));
    ro_a  = tx_drive(cyc, SA, 1'b1, 16'($urandom));
    lo_b  = tx_drive(cyc, SB, 1'b0, 16'($urandom));
    ro_b  = tx_drive(cyc, SB, 1'b1, 16'($urandom));
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
      drive();
    end
  endtask

  task automatic lit_at(input int n);
    step_to(n);
    @(negedge clk);
  endtask

  task automatic release_rst();
    #1;
    rst_n = 1'b1;
    cyc = 0;
    drive();
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_A", pack_a(), model(cyc, SA));
      check("model_B", pack_b(), model(cyc, SB));
    end
  end

  initial begin
    drive();
    repeat (3) @(posedge clk);
    #1;
    check("reset_A", pack_a(), 38'h0);
    check("reset_B", pack_b(), 38'h0);
    release_rst();

    lit_at(7);    check("sclk_lo", 38'(sclk_a), 38'h0);
    lit_at(8);    check("sclk_hi", 38'(sclk_a), 38'h1);
    lit_at(511);  check("lrclk_left", 38'(lrclk_a), 38'h0);
    lit_at(512);  check("lrclk_right", 38'(lrclk_a), 38'h1);
    lit_at(1023); check("codec_rst_lo", 38'(crst_a), 38'h0);
    lit_at(1024); check("codec_rst_hi", 38'(crst_a), 38'h1);
    lit_at(1623); check("B_valid_pre", 38'(valid_b), 38'h0);
    lit_at(1624); check("B_valid_rise", 38'(valid_b), 38'h1);
                  check("B_lft_in", 38'(lin_b), 38'h8001);
    lit_at(1631); check("B_valid_last", 38'(valid_b), 38'h1);
    lit_at(1632); check("B_valid_fall", 38'(valid_b), 38'h0);
    lit_at(1800); check("A_first_frame_suppressed", 38'(valid_a), 38'h0);
    lit_at(2823); check("A_valid_pre", 38'(valid_a), 38'h0);
    lit_at(2824); check("A_valid_rise", 38'(valid_a), 38'h1);
                  check("A_lft_in", 38'(lin_a), 38'h8001);
                  check("A_rht_in", 38'(rin_a), 38'h7FFE);
    lit_at(3071); check("A_valid_last", 38'(valid_a), 38'h1);
    lit_at(3072); check("A_valid_fall", 38'(valid_a), 38'h0);
                  check("A_lft_in_hold", 38'(lin_a), 38'h8001);
                  check("A_dac_delay", 38'(dac_a), 38'h0);
    lit_at(3088); check("A_dac_l_msb", 38'(dac_a), 38'h0);
    lit_at(3136); check("A_dac_l_b12", 38'(dac_a), 38'h1);
    lit_at(3392); check("A_dac_pad", 38'(dac_a), 38'h0);

    // Abort mid-frame at bit 20 of frame 3.
    step_to(3 * 1024 + 20 * 16 + 3);
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_A", pack_a(), 38'h0);
    check("abort_B", pack_b(), 38'h0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_A", pack_a(), 38'h0);
    release_rst();

    lit_at(1023); check("rerun_codec_rst_lo", 38'(crst_a), 38'h0);
    lit_at(1024); check("rerun_codec_rst_hi", 38'(crst_a), 38'h1);
    lit_at(2824); check("rerun_A_lft_in", 38'(lin_a), 38'h8001);
    lit_at(3600); check("A_dac_r_msb", 38'(dac_a), 38'h1);
    lit_at(3808); check("A_dac_r_b2", 38'(dac_a), 38'h1);
    step_to(8 * 1024);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
